shiftreg_sipo: RTL

Serial-in/parallel-out collector that assembles LSB-first bit streams from the bit-serial Montgomery multiplier datapath into WIDTH-bit words. It is the receive-side counterpart of the parallel-load operand serializer. It presents each completed word to the register/control side through a valid/ready handshake. An optional overflow detector flags words lost because the consumer did not acknowledge in time.

---
 rtl/shiftreg_pkg.sv | 14 +
 rtl/sipo_bitcnt.sv | 37 +++
 rtl/shiftreg_sipo.sv | 134 +++++++++++++
 3 files changed

// File: rtl/shiftreg_pkg.sv
// shiftreg_pkg: shared types and helpers for the SIPO collector.
// State enum and bit-counter width function.
package shiftreg_pkg;

  typedef enum logic {
    SIPO_IDLE,
    SIPO_SHIFT
  } sipo_state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sipo_bitcnt.sv
// sipo_bitcnt: counts accepted serial bits of one word.
// Wraps to 0 on the final bit so it never stores WIDTH.
module sipo_bitcnt
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       en,
  input  logic                       srst_n,
  input  logic                       clear,
  input  logic                       inc,
  output logic [cnt_w(WIDTH)-1:0]    count,
  output logic                       last
);

  localparam int CW = cnt_w(WIDTH);

  assign last = (count == CW'(WIDTH - 1));

  // bit counter: clear on start, step per accepted bit
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      count <= '0;
    end else if (!srst_n) begin
      count <= '0;
    end else if (en) begin
      if (clear) begin
        count <= '0;
      end else if (inc) begin
        count <= last ? '0 : count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/shiftreg_sipo.sv
// shiftreg_sipo: LSB-first serial-in/parallel-out word collector.
// Define SHIFTREG_SIPO_OVF_EN to build the sticky overflow flag.
module shiftreg_sipo
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             rst_mmm_i,
  input  logic             start_i,
  input  logic             bit_vld_i,
  input  logic             bit_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] word_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             ovf_o
);

  localparam int CW = cnt_w(WIDTH);

  sipo_state_e      state_q;
  sipo_state_e      state_d;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;
  logic             valid_q;
  logic             valid_d;
  logic             accept;
  logic             done;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [1:0]       dbg_unused;

  sipo_bitcnt #(
    .WIDTH(WIDTH)
  ) u_bitcnt (
    .clk   (clk),
    .rstb  (rstb),
    .en    (en),
    .srst_n(rst_mmm_i),
    .clear (start_i),
    .inc   (accept),
    .count (cnt),
    .last  (last)
  );

  // sr[0] is shifted out unread; cnt is only needed for last
  assign dbg_unused = {^cnt, sr_q[0]};

  // next state, shift data and handshake
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    word_d  = word_q;
    valid_d = valid_q;
    accept  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      SIPO_IDLE: begin
        if (start_i) begin
          state_d = SIPO_SHIFT;
          sr_d    = '0;
        end
      end
      SIPO_SHIFT: begin
        if (start_i) begin
          sr_d = '0;
        end else if (bit_vld_i) begin
          accept = 1'b1;
          sr_d   = {bit_i, sr_q[WIDTH-1:1]};
          if (last) begin
            done    = 1'b1;
            word_d  = {bit_i, sr_q[WIDTH-1:1]};
            state_d = SIPO_IDLE;
          end
        end
      end
      default: state_d = SIPO_IDLE;
    endcase
    if (done) begin
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= SIPO_IDLE;
      sr_q    <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else if (!rst_mmm_i) begin
      state_q <= SIPO_IDLE;
      sr_q    <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      sr_q    <= sr_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

`ifdef SHIFTREG_SIPO_OVF_EN
  logic ovf_q;

  // sticky: set when an unacked word is overwritten
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ovf_q <= 1'b0;
    end else if (!rst_mmm_i) begin
      ovf_q <= 1'b0;
    end else if (en && done && valid_q && !ready_i) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

  assign word_o  = word_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q == SIPO_SHIFT);

endmodule
